// File: rtl/mod12_wrap_monitor.sv
// rtl/mod12_wrap_monitor.sv - mod-12 counter monitor: wrap pulses, cascaded wrap counter, BCD image, error flags
module mod12_wrap_monitor #(
    parameter int WRAP_MOD = 10,
    parameter int WRAP_W   = 4
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [3:0]        cnt_in,
    input  logic              load,
    input  logic              updown,
    output logic              carry,
    output logic              borrow,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              wrap_tc,
    output logic              bcd_tens,
    output logic [3:0]        bcd_ones,
    output logic              range_err,
    output logic              seq_err
);

    localparam logic [WRAP_W-1:0] WRAP_MAX = WRAP_W'(WRAP_MOD - 1);

    logic [3:0]        prev_cnt_q, prev_cnt_d;
    logic              prev_valid_q, prev_valid_d;
    logic              load_q, load_d;
    logic              updown_q, updown_d;
    logic              carry_q, carry_d;
    logic              borrow_q, borrow_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic              wrap_tc_q, wrap_tc_d;
    logic              bcd_tens_q, bcd_tens_d;
    logic [3:0]        bcd_ones_q, bcd_ones_d;
    logic              range_err_q, range_err_d;
    logic              seq_err_q, seq_err_d;

    logic [3:0] exp_up, exp_dn;

    always_comb begin
        prev_cnt_d   = prev_cnt_q;
        prev_valid_d = prev_valid_q;
        load_d       = load;
        updown_d     = updown;
        carry_d      = 1'b0;
        borrow_d     = 1'b0;
        wrap_cnt_d   = wrap_cnt_q;
        wrap_tc_d    = 1'b0;
        bcd_tens_d   = bcd_tens_q;
        bcd_ones_d   = bcd_ones_q;
        range_err_d  = 1'b0;
        seq_err_d    = 1'b0;

        exp_up = (prev_cnt_q == 4'd11) ? 4'd0 : prev_cnt_q + 4'd1;
        exp_dn = (prev_cnt_q == 4'd0) ? 4'd11 : prev_cnt_q - 4'd1;

        if (cnt_in > 4'd11) begin
            range_err_d  = 1'b1;
            prev_valid_d = 1'b0;
        end else begin
            bcd_tens_d   = (cnt_in >= 4'd10);
            bcd_ones_d   = (cnt_in >= 4'd10) ? cnt_in - 4'd10 : cnt_in;
            prev_cnt_d   = cnt_in;
            prev_valid_d = 1'b1;
            // load_q/updown_q describe the transition that produced this sample
            if (prev_valid_q && !load_q) begin
                if (!updown_q) begin
                    if (cnt_in != exp_up)          seq_err_d = 1'b1;
                    else if (prev_cnt_q == 4'd11)  carry_d   = 1'b1;
                end else begin
                    if (cnt_in != exp_dn)          seq_err_d = 1'b1;
                    else if (prev_cnt_q == 4'd0)   borrow_d  = 1'b1;
                end
            end
        end

        if (carry_d) begin
            wrap_tc_d  = (wrap_cnt_q == WRAP_MAX);
            wrap_cnt_d = (wrap_cnt_q == WRAP_MAX) ? '0 : wrap_cnt_q + 1'b1;
        end else if (borrow_d) begin
            wrap_tc_d  = (wrap_cnt_q == '0);
            wrap_cnt_d = (wrap_cnt_q == '0) ? WRAP_MAX : wrap_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            prev_cnt_q   <= '0;
            prev_valid_q <= 1'b0;
            load_q       <= 1'b0;
            updown_q     <= 1'b0;
            carry_q      <= 1'b0;
            borrow_q     <= 1'b0;
            wrap_cnt_q   <= '0;
            wrap_tc_q    <= 1'b0;
            bcd_tens_q   <= 1'b0;
            bcd_ones_q   <= '0;
            range_err_q  <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            prev_cnt_q   <= prev_cnt_d;
            prev_valid_q <= prev_valid_d;
            load_q       <= load_d;
            updown_q     <= updown_d;
            carry_q      <= carry_d;
            borrow_q     <= borrow_d;
            wrap_cnt_q   <= wrap_cnt_d;
            wrap_tc_q    <= wrap_tc_d;
            bcd_tens_q   <= bcd_tens_d;
            bcd_ones_q   <= bcd_ones_d;
            range_err_q  <= range_err_d;
            seq_err_q    <= seq_err_d;
        end
    end

    assign carry     = carry_q;
    assign borrow    = borrow_q;
    assign wrap_cnt  = wrap_cnt_q;
    assign wrap_tc   = wrap_tc_q;
    assign bcd_tens  = bcd_tens_q;
    assign bcd_ones  = bcd_ones_q;
    assign range_err = range_err_q;
    assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_mod12_wrap_monitor.sv
// tb/tb_mod12_wrap_monitor.sv - randomized and directed bench for mod12_wrap_monitor
module tb_mod12_wrap_monitor;

    localparam int WM = 10;

    logic       clock;
    logic       rst;
    logic [3:0] cnt_in;
    logic       load;
    logic       updown;
    logic       carry, borrow, wrap_tc, bcd_tens, range_err, seq_err;
    logic [3:0] wrap_cnt;
    logic [3:0] bcd_ones;

    mod12_wrap_monitor #(.WRAP_MOD(WM), .WRAP_W(4)) dut (
        .clock(clock), .rst(rst), .cnt_in(cnt_in), .load(load), .updown(updown),
        .carry(carry), .borrow(borrow), .wrap_cnt(wrap_cnt), .wrap_tc(wrap_tc),
        .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .range_err(range_err), .seq_err(seq_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: integer arithmetic on the sampled stream
    int m_prev, m_wrap, e_ones;
    bit m_valid, m_load, m_ud;
    bit e_carry, e_borrow, e_tc, e_tens, e_range, e_seq;

    wire [13:0] dut_vec = {carry, borrow, wrap_cnt, wrap_tc, bcd_tens, bcd_ones, range_err, seq_err};

    function automatic logic [13:0] exp_vec();
        return {e_carry, e_borrow, 4'(m_wrap), e_tc, e_tens, 4'(e_ones), e_range, e_seq};
    endfunction

    task automatic model_step(input int s, input bit ld, input bit ud, input bit r);
        int nxt;
        e_carry = 0; e_borrow = 0; e_tc = 0; e_range = 0; e_seq = 0;
        if (r) begin
            m_prev = 0; m_valid = 0; m_load = 0; m_ud = 0; m_wrap = 0;
            e_tens = 0; e_ones = 0;
            return;
        end
        if (s > 11) begin
            e_range = 1;
            m_valid = 0;
        end else begin
            e_tens = (s >= 10);
            e_ones = s % 10;
            if (m_valid && !m_load) begin
                nxt = (m_prev + (m_ud ? 11 : 1)) % 12;
                if (s != nxt)              e_seq    = 1;
                else if (!m_ud && nxt == 0) e_carry  = 1;
                else if (m_ud && nxt == 11) e_borrow = 1;
            end
            m_prev  = s;
            m_valid = 1;
        end
        if (e_carry) begin
            m_wrap = (m_wrap + 1) % WM;
            e_tc   = (m_wrap == 0);
        end else if (e_borrow) begin
            m_wrap = (m_wrap + WM - 1) % WM;
            e_tc   = (m_wrap == WM - 1);
        end
        m_load = ld;
        m_ud   = ud;
    endtask

    task automatic cyc(input int s, input bit ld, input bit ud, input bit r);
        @(negedge clock);
        cnt_in = 4'(s); load = ld; updown = ud; rst = r;
        @(posedge clock);
        model_step(s, ld, ud, r);
        #1;
    endtask

    task automatic test_reset();
        cyc(7, 1, 1, 1);
        cyc(3, 0, 0, 1);
        n_tests++;
        if (dut_vec !== 14'd0) begin
            n_fail++; $display("FAIL reset_state got=%h want=%h", dut_vec, 14'd0);
        end
    endtask

    task automatic test_count_up();
        int ncarry = 0, nseq = 0;
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 14; i++) begin
            cyc(i % 12, 0, 0, 0);
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL up_step%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
            ncarry += int'(carry);
            nseq   += int'(seq_err);
            if (i == 11) begin
                n_tests++;
                if ({bcd_tens, bcd_ones} !== 5'h11) begin
                    n_fail++; $display("FAIL up_bcd11 got=%h want=%h", {bcd_tens, bcd_ones}, 5'h11);
                end
            end
            if (i == 12) begin
                n_tests++;
                if (carry !== 1'b1) begin
                    n_fail++; $display("FAIL up_carry_pos got=%b want=1", carry);
                end
            end
        end
        n_tests++;
        if (ncarry != 1 || nseq != 0 || wrap_cnt !== 4'd1) begin
            n_fail++; $display("FAIL up_summary got carries=%0d seq=%0d wrap=%0d want 1 0 1", ncarry, nseq, wrap_cnt);
        end
    endtask

    task automatic test_count_down();
        int s = 2, nbor = 0, ntc = 0;
        for (int k = 0; k < 16; k++) begin
            cyc(s, 0, 1, 0);
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL dn_step%0d got=%h want=%h", k, dut_vec, exp_vec());
            end
            nbor += int'(borrow);
            ntc  += int'(wrap_tc);
            s = (s == 0) ? 11 : s - 1;
        end
        n_tests++;
        if (nbor != 2 || ntc != 1 || wrap_cnt !== 4'd9 || wrap_tc !== 1'b1) begin
            n_fail++; $display("FAIL dn_summary got bor=%0d tc=%0d wrap=%0d want 2 1 9", nbor, ntc, wrap_cnt);
        end
    endtask

    task automatic test_wrap_cascade();
        int ncarry = 0, ntc = 0;
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 121; i++) begin
            cyc(i % 12, 0, 0, 0);
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL casc_step%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
            ncarry += int'(carry);
            ntc    += int'(wrap_tc);
            if (i == 108) begin
                n_tests++;
                if (wrap_cnt !== 4'd9) begin
                    n_fail++; $display("FAIL casc_nine got=%0d want=9", wrap_cnt);
                end
            end
        end
        n_tests++;
        if (ncarry != 10 || ntc != 1 || wrap_tc !== 1'b1 || wrap_cnt !== 4'd0) begin
            n_fail++; $display("FAIL casc_summary got carry=%0d tc=%0d wrap=%0d want 10 1 0", ncarry, ntc, wrap_cnt);
        end
    endtask

    task automatic test_load();
        int seq_s[6] = '{9, 10, 11, 0, 1, 2};
        bit seq_l[6] = '{0, 0, 1, 0, 0, 1};
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            cyc(seq_s[i], seq_l[i], 0, 0);
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL load_step%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
            if (i == 3) begin
                n_tests++;
                if ({carry, seq_err} !== 2'b00) begin
                    n_fail++; $display("FAIL load_no_carry got=%b want=00", {carry, seq_err});
                end
            end
        end
        cyc(7, 0, 0, 0);
        n_tests++;
        if (seq_err !== 1'b0 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL load_jump got=%h want=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_range_err();
        cyc(0, 0, 0, 1);
        cyc(4, 0, 0, 0);
        cyc(13, 0, 0, 0);
        n_tests++;
        if ({range_err, seq_err, bcd_tens, bcd_ones} !== 7'b1000100 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL range_13 got=%h want=%h", dut_vec, exp_vec());
        end
        cyc(5, 0, 0, 0);
        n_tests++;
        if ({range_err, seq_err, bcd_ones} !== 6'b000101 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL range_resume got=%h want=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_seq_err_reset();
        cyc(0, 0, 0, 1);
        cyc(2, 0, 0, 0);
        cyc(3, 0, 0, 0);
        cyc(7, 0, 0, 0);
        n_tests++;
        if ({carry, borrow, range_err, seq_err} !== 4'b0001 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL seq_jump got=%h want=%h", dut_vec, exp_vec());
        end
        cyc(8, 0, 0, 0);
        cyc(9, 0, 0, 1);
        n_tests++;
        if (dut_vec !== 14'd0) begin
            n_fail++; $display("FAIL mid_reset got=%h want=0", dut_vec);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(i, 0, 0, 0);
            n_tests++;
            if ({carry, borrow, wrap_tc, range_err, seq_err} !== 5'b0 || dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL resume%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int cnt = 0, s;
        bit ld = 0, ud = 0, r;
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 63) == 0);
            if (r)       cnt = 0;
            else if (ld) cnt = $urandom_range(0, 11);
            else         cnt = (cnt + (ud ? 11 : 1)) % 12;
            s  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 15)) : cnt;
            ld = ($urandom_range(0, 7) == 0);
            ud = ($urandom_range(0, 3) == 0) ? ~ud : ud;
            cyc(s, ld, ud, r);
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL rand_step%0d s=%0d got=%h want=%h", i, s, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1; cnt_in = 4'd0; load = 1'b0; updown = 1'b0;
        model_step(0, 0, 0, 1);
        test_reset();
        test_count_up();
        test_count_down();
        test_wrap_cascade();
        test_load();
        test_range_err();
        test_seq_err_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
